generic_fifo_sc: RTL and testbench

- Single-clock synchronous FIFO with a registered read-data output, full/empty flags, and programmable near-full/near-empty thresholds.
- Also provides registered copies of the flags and a 2-bit fill-level indicator.
- Used as a general buffering element between producer and consumer logic in the same clock domain.
- Storage depth is 2**aw words.

---
 rtl/generic_fifo_pkg.sv | 13 +
 rtl/generic_fifo_sc_ram.sv | 32 +++
 rtl/generic_fifo_sc.sv | 125 ++++++++++++
 tb/tb_generic_fifo_sc.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/generic_fifo_pkg.sv
// rtl/generic_fifo_pkg.sv - shared level encodings and depth helper for generic_fifo_sc
package generic_fifo_pkg;

  localparam logic [1:0] LVL_LT25 = 2'b00;
  localparam logic [1:0] LVL_LT50 = 2'b01;
  localparam logic [1:0] LVL_LT75 = 2'b10;
  localparam logic [1:0] LVL_GE75 = 2'b11;

  function automatic int fifo_depth(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/generic_fifo_sc_ram.sv
// rtl/generic_fifo_sc_ram.sv - 2**aw x dw register array, sync write port, registered read port
module generic_fifo_sc_ram
  import generic_fifo_pkg::*;
#(
  parameter int dw = 8,
  parameter int aw = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [aw-1:0] waddr,
  input  logic [dw-1:0] wdata,
  input  logic          re,
  input  logic [aw-1:0] raddr,
  output logic [dw-1:0] rdata
);

  localparam int DEPTH = fifo_depth(aw);

  logic [dw-1:0] mem [DEPTH];

  // Storage is deliberately left unreset; only the output register clears.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/generic_fifo_sc.sv
// rtl/generic_fifo_sc.sv - single-clock FIFO with threshold flags; GENERIC_FIFO_SC_ERR_EN adds sticky overflow/underflow
module generic_fifo_sc
  import generic_fifo_pkg::*;
#(
  parameter int dw = 8,
  parameter int aw = 8,
  parameter int n  = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [dw-1:0] din,
  input  logic          we,
  output logic [dw-1:0] dout,
  input  logic          re,
  output logic          full,
  output logic          empty,
  output logic          full_r,
  output logic          empty_r,
  output logic          full_n,
  output logic          empty_n,
  output logic          full_n_r,
  output logic          empty_n_r,
  output logic [1:0]    level
`ifdef GENERIC_FIFO_SC_ERR_EN
  ,
  output logic          overflow,
  output logic          underflow
`endif
);

  localparam int DEPTH = fifo_depth(aw);
  localparam logic [aw:0] CNT_FULL   = (aw+1)'(DEPTH);
  localparam logic [aw:0] FULL_N_TH  = (aw+1)'(DEPTH - n);
  localparam logic [aw:0] EMPTY_N_TH = (aw+1)'(n);
  localparam logic [aw:0] Q1         = (aw+1)'(DEPTH / 4);
  localparam logic [aw:0] Q2         = (aw+1)'(DEPTH / 2);
  localparam logic [aw:0] Q3         = (aw+1)'((3 * DEPTH) / 4);

  logic [aw-1:0] wp, rp;
  logic [aw:0]   cnt, cnt_nxt;
  logic          wr, rd;

  // clr outranks both ports, so neither memory nor dout moves on a clear edge.
  assign wr = we & ~full & ~clr;
  assign rd = re & ~empty & ~clr;

  always_comb begin
    cnt_nxt = cnt;
    if (clr)             cnt_nxt = '0;
    else if (wr && !rd)  cnt_nxt = cnt + 1'b1;
    else if (rd && !wr)  cnt_nxt = cnt - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
      if (clr) begin
        wp <= '0;
        rp <= '0;
      end else begin
        if (wr) wp <= wp + 1'b1;
        if (rd) rp <= rp + 1'b1;
      end
    end
  end

  assign full    = (cnt == CNT_FULL);
  assign empty   = (cnt == '0);
  assign full_n  = (cnt >= FULL_N_TH);
  assign empty_n = (cnt <= EMPTY_N_TH);

  // Registered flags decode the next count so they track the live flags without lag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_r    <= 1'b0;
      empty_r   <= 1'b1;
      full_n_r  <= 1'b0;
      empty_n_r <= 1'b1;
    end else begin
      full_r    <= (cnt_nxt == CNT_FULL);
      empty_r   <= (cnt_nxt == '0);
      full_n_r  <= (cnt_nxt >= FULL_N_TH);
      empty_n_r <= (cnt_nxt <= EMPTY_N_TH);
    end
  end

  always_comb begin
    level = LVL_GE75;
    if (cnt < Q1)      level = LVL_LT25;
    else if (cnt < Q2) level = LVL_LT50;
    else if (cnt < Q3) level = LVL_LT75;
  end

  generic_fifo_sc_ram #(.dw(dw), .aw(aw)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr),
    .waddr (wp),
    .wdata (din),
    .re    (rd),
    .raddr (rp),
    .rdata (dout)
  );

`ifdef GENERIC_FIFO_SC_ERR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (we && full)  overflow  <= 1'b1;
      if (re && empty) underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_generic_fifo_sc.sv
// tb/tb_generic_fifo_sc.sv - randomized self-checking bench for generic_fifo_sc against a queue model
module tb_generic_fifo_sc;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int N = 9;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst, clr, we, re;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          full, empty, full_r, empty_r, full_n, empty_n, full_n_r, empty_n_r;
  logic [1:0]    level;
`ifdef GENERIC_FIFO_SC_ERR_EN
  logic          overflow, underflow;
`endif

  int n_checks = 0;
  int n_fail = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_dout = '0;

  generic_fifo_sc #(.dw(DW), .aw(AW), .n(N)) dut (
    .clk(clk), .rst(rst), .clr(clr), .din(din), .we(we), .dout(dout), .re(re),
    .full(full), .empty(empty), .full_r(full_r), .empty_r(empty_r),
    .full_n(full_n), .empty_n(empty_n), .full_n_r(full_n_r), .empty_n_r(empty_n_r),
    .level(level)
`ifdef GENERIC_FIFO_SC_ERR_EN
    , .overflow(overflow), .underflow(underflow)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] model_level();
    int quart;
    quart = (q.size() * 4) / DEPTH;
    return (quart > 3) ? 2'd3 : 2'(quart);
  endfunction

  // Advance the model by one edge using the current inputs, then sample 3 ns after the edge.
  task automatic step();
    bit w, r;
    if (clr) q.delete();
    else begin
      w = we && (q.size() < DEPTH);
      r = re && (q.size() > 0);
      if (r) exp_dout = q.pop_front();
      if (w) q.push_back(din);
    end
    @(posedge clk);
    #3;
  endtask

  task automatic do_write(input logic [DW-1:0] v);
    we = 1'b1; din = v; step(); we = 1'b0;
  endtask

  task automatic do_read();
    re = 1'b1; step(); re = 1'b0;
  endtask

  task automatic do_idle(input int k);
    repeat (k) step();
  endtask

  task automatic test_reset();
    rst = 1'b0; clr = 1'b0; we = 1'b0; re = 1'b0; din = '0;
    q.delete(); exp_dout = '0;
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    step();
    n_checks++; if (empty !== 1'b1 || empty_r !== 1'b1) begin n_fail++; $display("FAIL reset_empty: empty=%b empty_r=%b want 1/1", empty, empty_r); end
    n_checks++; if (empty_n !== 1'b1 || empty_n_r !== 1'b1) begin n_fail++; $display("FAIL reset_empty_n: %b/%b want 1/1", empty_n, empty_n_r); end
    n_checks++; if (full !== 1'b0 || full_r !== 1'b0 || full_n !== 1'b0 || full_n_r !== 1'b0) begin n_fail++; $display("FAIL reset_full: %b%b%b%b want 0000", full, full_r, full_n, full_n_r); end
    n_checks++; if (level !== 2'b00) begin n_fail++; $display("FAIL reset_level: got %b want 00", level); end
    n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h want 00", dout); end
  endtask

  task automatic test_single();
    logic [DW-1:0] v;
    for (int i = 0; i < 5; i++) begin
      v = 8'($urandom);
      do_write(v);
      do_read();
      n_checks++; if (dout !== v || dout !== exp_dout) begin n_fail++; $display("FAIL single_data[%0d]: got %h want %h", i, dout, v); end
      n_checks++; if (empty !== 1'b1 || empty_r !== 1'b1) begin n_fail++; $display("FAIL single_empty[%0d]: %b/%b want 1/1", i, empty, empty_r); end
    end
  endtask

  task automatic test_bursts();
    for (int b = 2; b <= 4; b++) begin
      for (int i = 0; i < b; i++) begin do_write(8'($urandom)); do_idle($urandom_range(0, 4)); end
      for (int i = 0; i < b; i++) begin
        do_read();
        n_checks++; if (dout !== exp_dout) begin n_fail++; $display("FAIL burst%0d_data[%0d]: got %h want %h", b, i, dout, exp_dout); end
        do_idle($urandom_range(0, 4));
      end
      n_checks++; if (empty !== 1'b1 || q.size() != 0) begin n_fail++; $display("FAIL burst%0d_empty: got %b want 1", b, empty); end
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= DEPTH; i++) begin
      do_write(8'($urandom));
      if (i == 246) begin n_checks++; if (full_n !== 1'b0) begin n_fail++; $display("FAIL fill_full_n_246: got %b want 0", full_n); end end
      if (i == 247) begin n_checks++; if (full_n !== 1'b1 || full_n_r !== 1'b1) begin n_fail++; $display("FAIL fill_full_n_247: %b/%b want 1/1", full_n, full_n_r); end end
      if (i == 255) begin n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL fill_full_255: got %b want 0", full); end end
    end
    n_checks++; if (full !== 1'b1 || full_r !== 1'b1) begin n_fail++; $display("FAIL fill_full: %b/%b want 1/1", full, full_r); end
    n_checks++; if (level !== 2'b11) begin n_fail++; $display("FAIL fill_level: got %b want 11", level); end
    do_write(8'($urandom));
    n_checks++; if (full !== 1'b1 || empty !== 1'b0) begin n_fail++; $display("FAIL overfill_flags: full=%b empty=%b want 1/0", full, empty); end
`ifdef GENERIC_FIFO_SC_ERR_EN
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_flag: got %b want 1", overflow); end
`endif
    for (int i = 0; i < DEPTH; i++) begin
      do_read();
      n_checks++; if (dout !== exp_dout) begin n_fail++; $display("FAIL fill_read[%0d]: got %h want %h", i, dout, exp_dout); end
    end
    n_checks++; if (empty !== 1'b1 || empty_r !== 1'b1 || level !== 2'b00) begin n_fail++; $display("FAIL fill_drained: empty=%b empty_r=%b level=%b", empty, empty_r, level); end
  endtask

  task automatic test_levels();
    for (int i = 1; i <= 130; i++) begin
      do_write(8'($urandom));
      if (i == 10) begin n_checks++; if (empty_n !== 1'b0 || empty_n_r !== 1'b0) begin n_fail++; $display("FAIL lvl_empty_n_10: %b/%b want 0/0", empty_n, empty_n_r); end end
      if (i == 63 || i == 64 || i == 127 || i == 128) begin
        n_checks++; if (level !== model_level()) begin n_fail++; $display("FAIL lvl_at_%0d: got %b want %b", i, level, model_level()); end
      end
    end
    while (q.size() > 10) do_read();
    n_checks++; if (empty_n !== 1'b0) begin n_fail++; $display("FAIL drain_empty_n_10: got %b want 0", empty_n); end
    do_read();
    n_checks++; if (empty_n !== 1'b1 || empty_n_r !== 1'b1) begin n_fail++; $display("FAIL drain_empty_n_9: %b/%b want 1/1", empty_n, empty_n_r); end
    n_checks++; if (dout !== exp_dout) begin n_fail++; $display("FAIL drain_data: got %h want %h", dout, exp_dout); end
    clr = 1'b1; step(); clr = 1'b0;
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_clr: got %b want 1", empty); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] held;
    for (int i = 0; i < 5; i++) do_write(8'($urandom));
    we = 1'b1; re = 1'b1; din = 8'($urandom); step(); we = 1'b0; re = 1'b0;
    n_checks++; if (dout !== exp_dout) begin n_fail++; $display("FAIL simul_data: got %h want %h", dout, exp_dout); end
    n_checks++; if (empty !== 1'b0 || level !== 2'b00 || q.size() != 5) begin n_fail++; $display("FAIL simul_flags: empty=%b level=%b", empty, level); end
    held = exp_dout;
    clr = 1'b1; re = 1'b1; we = 1'b1; step(); clr = 1'b0; re = 1'b0; we = 1'b0;
    n_checks++; if (empty !== 1'b1 || empty_r !== 1'b1 || level !== 2'b00) begin n_fail++; $display("FAIL clr_flags: empty=%b empty_r=%b level=%b", empty, empty_r, level); end
    n_checks++; if (dout !== held) begin n_fail++; $display("FAIL clr_dout: got %h want %h", dout, held); end
    do_read();
    n_checks++; if (dout !== held || empty !== 1'b1) begin n_fail++; $display("FAIL underrun_hold: dout=%h want %h empty=%b", dout, held, empty); end
`ifdef GENERIC_FIFO_SC_ERR_EN
    n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL underflow_flag: got %b want 1", underflow); end
`endif
  endtask

  task automatic test_mid_reset();
    logic [DW-1:0] v;
    for (int i = 0; i < 3; i++) do_write(8'($urandom));
    do_read();
    rst = 1'b0;
    #1;
    q.delete(); exp_dout = '0;
    n_checks++; if (empty !== 1'b1 || dout !== 8'h00 || empty_r !== 1'b1) begin n_fail++; $display("FAIL async_reset: empty=%b empty_r=%b dout=%h", empty, empty_r, dout); end
    rst = 1'b1;
    v = 8'($urandom);
    do_write(v);
    do_read();
    n_checks++; if (dout !== v || empty !== 1'b1) begin n_fail++; $display("FAIL post_reset_data: got %h want %h", dout, v); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_bursts();
    test_fill();
    test_levels();
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
